// File: rtl/bcd_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seg_pkg
// Brief    : Shared types and constants for the BCD seven-segment display:
//            conversion FSM states, active-low segment patterns and the
//            BCD accumulator sizing function.
//            Related build macro: BCD_SEG_LEADING_ZERO_BLANK_EN (used by
//            bcd_seg_display).
// Revision : 1.0 - initial release
// ============================================================================
package bcd_seg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] c_SEG_0     = 7'b100_0000;
  localparam logic [6:0] c_SEG_1     = 7'b111_1001;
  localparam logic [6:0] c_SEG_2     = 7'b010_0100;
  localparam logic [6:0] c_SEG_3     = 7'b011_0000;
  localparam logic [6:0] c_SEG_4     = 7'b001_1001;
  localparam logic [6:0] c_SEG_5     = 7'b001_0010;
  localparam logic [6:0] c_SEG_6     = 7'b000_0010;
  localparam logic [6:0] c_SEG_7     = 7'b111_1000;
  localparam logic [6:0] c_SEG_8     = 7'b000_0000;
  localparam logic [6:0] c_SEG_9     = 7'b001_0000;
  localparam logic [6:0] c_SEG_DASH  = 7'b011_1111;
  localparam logic [6:0] c_SEG_BLANK = 7'b111_1111;

  // Number of BCD nibbles needed for a WIDTH-bit value: ceil(width*log10(2)),
  // evaluated with integer arithmetic, never fewer than the displayed digits.
  function automatic int bcd_nibbles(input int width, input int digits);
    int n;
    n = (width * 30103 + 99999) / 100000;
    return (n < digits) ? digits : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Brief    : Combinational nibble to active-low seven-segment decoder.
//            Dash overrides blank; blank overrides the digit; values above 9
//            are shown blank.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
  import bcd_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  // Select the segment pattern for the current digit
  always_comb begin
    o_seg = c_SEG_BLANK;
    if (i_dash) begin
      o_seg = c_SEG_DASH;
    end else if (!i_blank) begin
      case (i_nib)
        4'd0:    o_seg = c_SEG_0;
        4'd1:    o_seg = c_SEG_1;
        4'd2:    o_seg = c_SEG_2;
        4'd3:    o_seg = c_SEG_3;
        4'd4:    o_seg = c_SEG_4;
        4'd5:    o_seg = c_SEG_5;
        4'd6:    o_seg = c_SEG_6;
        4'd7:    o_seg = c_SEG_7;
        4'd8:    o_seg = c_SEG_8;
        4'd9:    o_seg = c_SEG_9;
        default: o_seg = c_SEG_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seg_display
// Brief    : Sequential double-dabble binary-to-BCD converter feeding a
//            multiplexed, active-low seven-segment display.
//            Build macro BCD_SEG_LEADING_ZERO_BLANK_EN: blank leading zero
//            digits (digit 0 always shown, overflow dash still wins).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_seg_display
  import bcd_seg_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 4,
  parameter int REFRESH_BITS = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  VALUE,
  input  logic              LOAD,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVF,
  output logic [DIGITS-1:0] AN,
  output logic [6:0]        seg
);

  localparam int c_NIB   = bcd_nibbles(WIDTH, DIGITS);
  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam int c_DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_SHIFT = c_CNT_W'(WIDTH - 1);
  localparam logic [c_DIG_W-1:0] c_LAST_DIG   = c_DIG_W'(DIGITS - 1);

  state_t                  r_state;
  logic [WIDTH-1:0]        r_shift;
  logic [4*c_NIB-1:0]      r_bcd;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [4*DIGITS-1:0]     r_disp;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_ovf;
  logic [REFRESH_BITS-1:0] r_pre;
  logic [c_DIG_W-1:0]      r_dig;

  logic [4*c_NIB-1:0]      w_bcd_adj;
  logic [4*c_NIB-1:0]      w_bcd_next;
  logic                    w_carry_out;
  logic                    w_ovf_next;
  logic [3:0]              w_nib;
  logic                    w_blank;

  // Add-3 correction on every nibble before the shift
  generate
    for (genvar gi = 0; gi < c_NIB; gi++) begin : g_adj
      assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] > 4'd4) ?
                                    (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
    end
  endgenerate

  // One-bit left shift of the corrected accumulator, MSB of the binary in.
  // The bit shifted out of the top nibble would be a lost digit, so it is
  // folded into the overflow flag (it stays zero with correct sizing).
  assign w_bcd_next  = {w_bcd_adj[4*c_NIB-2:0], r_shift[WIDTH-1]};
  assign w_carry_out = w_bcd_adj[4*c_NIB-1];

  generate
    if (c_NIB > DIGITS) begin : g_ovf
      assign w_ovf_next = w_carry_out | (|w_bcd_next[4*c_NIB-1:4*DIGITS]);
    end else begin : g_no_ovf
      assign w_ovf_next = w_carry_out;
    end
  endgenerate

  // Conversion FSM; display, OVF and DONE land together on entry to FINISH
  // so the DONE pulse coincides with the first cycle the new value is shown
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_disp  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (LOAD) begin
            r_shift <= VALUE;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd   <= w_bcd_next;
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST_SHIFT) begin
            r_disp  <= w_bcd_next[4*DIGITS-1:0];
            r_ovf   <= w_ovf_next;
            r_done  <= 1'b1;
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Refresh prescaler and digit index; index wraps at DIGITS-1
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pre <= '0;
      r_dig <= '0;
    end else begin
      r_pre <= r_pre + REFRESH_BITS'(1);
      if (&r_pre) begin
        r_dig <= (r_dig == c_LAST_DIG) ? '0 : (r_dig + c_DIG_W'(1));
      end
    end
  end

  // Select the displayed nibble for the current digit
  always_comb begin
    w_nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_dig == c_DIG_W'(i)) w_nib = r_disp[4*i +: 4];
    end
  end

`ifdef BCD_SEG_LEADING_ZERO_BLANK_EN
  // Blank the current digit when it and every digit above it are zero
  always_comb begin
    logic w_upper_zero;
    w_blank      = 1'b0;
    w_upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_upper_zero = w_upper_zero && (r_disp[4*i +: 4] == 4'd0);
      if ((r_dig == c_DIG_W'(i)) && w_upper_zero) w_blank = 1'b1;
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  // Active-low anode enable for the current digit only
  always_comb begin
    AN = '1;
    for (int i = 0; i < DIGITS; i++) begin
      AN[i] = (r_dig != c_DIG_W'(i));
    end
  end

  seg7_decode u_decode (
    .i_nib   (w_nib),
    .i_blank (w_blank),
    .i_dash  (r_ovf),
    .o_seg   (seg)
  );

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign OVF  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_seg_display
// Brief    : Self-checking bench for bcd_seg_display: three instances
//            (4, 2 and 3 digits, fast refresh) checked against a decimal
//            reference model of the displayed digits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_seg_display;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic [7:0] v1, v2, v3;
  logic       l1, l2, l3;
  logic       busy1, busy2, busy3, done1, done2, done3, ovf1, ovf2, ovf3;
  logic [3:0] an1;
  logic [1:0] an2;
  logic [2:0] an3;
  logic [6:0] seg1, seg2, seg3;

  int errors = 0;
  int checks = 0;

  bcd_seg_display #(.WIDTH(8), .DIGITS(4), .REFRESH_BITS(2)) u_dut1 (
    .CLK(CLK), .RST(RST), .VALUE(v1), .LOAD(l1), .BUSY(busy1), .DONE(done1),
    .OVF(ovf1), .AN(an1), .seg(seg1));
  bcd_seg_display #(.WIDTH(8), .DIGITS(2), .REFRESH_BITS(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .VALUE(v2), .LOAD(l2), .BUSY(busy2), .DONE(done2),
    .OVF(ovf2), .AN(an2), .seg(seg2));
  bcd_seg_display #(.WIDTH(8), .DIGITS(3), .REFRESH_BITS(2)) u_dut3 (
    .CLK(CLK), .RST(RST), .VALUE(v3), .LOAD(l3), .BUSY(busy3), .DONE(done3),
    .OVF(ovf3), .AN(an3), .seg(seg3));

  logic [7:0] an_x  [3];
  logic [6:0] seg_x [3];
  logic [2:0] busy_x, done_x;

  always_comb begin
    an_x[0]  = {4'hF, an1};
    an_x[1]  = {6'h3F, an2};
    an_x[2]  = {5'h1F, an3};
    seg_x[0] = seg1;
    seg_x[1] = seg2;
    seg_x[2] = seg3;
    busy_x   = {busy3, busy2, busy1};
    done_x   = {done3, done2, done1};
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int digits, input int d);
    int lim = 1;
    int pd  = 1;
    for (int i = 0; i < digits; i++) lim *= 10;
    for (int i = 0; i < d; i++) pd *= 10;
    if (v >= lim) return 7'h3F;
`ifdef BCD_SEG_LEADING_ZERO_BLANK_EN
    if (d > 0 && v < pd) return 7'h7F;
`endif
    return seg_of((v / pd) % 10);
  endfunction

  // ---------------- stimulus helpers ----------------
  logic [6:0] got [8];
  int         an_errs;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int w, input logic ld, input logic [7:0] v);
    case (w)
      0: begin l1 = ld; v1 = v; end
      1: begin l2 = ld; v2 = v; end
      default: begin l3 = ld; v3 = v; end
    endcase
  endtask

  // Observe one full refresh period, recording the pattern seen per digit
  task automatic scan(input int w, input int digits);
    an_errs = 0;
    for (int k = 0; k < 8; k++) got[k] = 7'h55;
    for (int c = 0; c < 4 * digits; c++) begin
      int lows = 0;
      for (int k = 0; k < digits; k++) begin
        if (!an_x[w][k]) begin
          lows++;
          got[k] = seg_x[w];
        end
      end
      if (lows != 1) an_errs++;
      tick();
    end
  endtask

  // Pulse LOAD for one cycle; lat = cycle index of DONE (-1 on timeout).
  // Returns positioned in the cycle after DONE.
  task automatic convert(input int w, input logic [7:0] val, output int lat, output int busy_bad);
    drive(w, 1'b1, val);
    tick();
    drive(w, 1'b0, 8'd0);
    lat = -1;
    busy_bad = 0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (!busy_x[w]) busy_bad++;
      if (done_x[w]) lat = c;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    RST = 1'b1;
    tick();
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done1); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf1); end
    checks++; if (an1 !== 4'b1110) begin errors++; $display("FAIL reset_an got=%b exp=1110", an1); end
    checks++; if (seg1 !== 7'h40) begin errors++; $display("FAIL reset_seg got=%h exp=40", seg1); end
    RST = 1'b0;
  endtask

  task automatic test_scan_an;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int c = 0; c < 16; c++) begin
      logic [2:0] exp_an;
      exp_an = ~(3'b001 << ((c / 4) % 3));
      checks++;
      if (an3 !== exp_an) begin
        errors++; $display("FAIL scan_an cycle=%0d got=%b exp=%b", c, an3, exp_an);
      end
      tick();
    end
  endtask

  task automatic test_conversion;
    int lat, bb;
    convert(0, 8'd255, lat, bb);
    checks++; if (lat !== 9) begin errors++; $display("FAIL conv_latency got=%0d exp=9", lat); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL conv_busy_low_cycles got=%0d exp=0", bb); end
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL conv_after_done busy=%b done=%b exp=0,0", busy1, done1); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL conv_ovf got=%b exp=0", ovf1); end
    scan(0, 4);
    checks++; if (an_errs !== 0) begin errors++; $display("FAIL conv_an_onehot bad=%0d exp=0", an_errs); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== exp_seg(255, 4, k)) begin
        errors++; $display("FAIL conv_digit%0d got=%h exp=%h", k, got[k], exp_seg(255, 4, k)); end
    end
  endtask

  task automatic test_ovf;
    int lat, bb;
    convert(1, 8'd100, lat, bb);
    checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL ovf100 got=%b exp=1", ovf2); end
    scan(1, 2);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got[k] !== 7'h3F) begin errors++; $display("FAIL ovf100_dash%0d got=%h exp=3f", k, got[k]); end
    end
    convert(1, 8'd99, lat, bb);
    checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL ovf99 got=%b exp=0", ovf2); end
    scan(1, 2);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got[k] !== 7'h10) begin errors++; $display("FAIL ovf99_digit%0d got=%h exp=10", k, got[k]); end
    end
  endtask

  task automatic test_load_ignored;
    int dones = 0;
    drive(0, 1'b1, 8'd42);
    tick();
    for (int c = 1; c <= 30; c++) begin
      if (c == 3) drive(0, 1'b1, 8'd7);
      else        drive(0, 1'b0, 8'd0);
      if (done1) dones++;
      tick();
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_pulses got=%0d exp=1", dones); end
    scan(0, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== exp_seg(42, 4, k)) begin
        errors++; $display("FAIL ignore_digit%0d got=%h exp=%h", k, got[k], exp_seg(42, 4, k)); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bb;
    convert(0, 8'd123, lat, bb);
    convert(0, 8'd77, lat, bb);
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_latency got=%0d exp=9", lat); end
    scan(0, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== exp_seg(77, 4, k)) begin
        errors++; $display("FAIL b2b_digit%0d got=%h exp=%h", k, got[k], exp_seg(77, 4, k)); end
    end
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    drive(0, 1'b1, 8'd200);
    tick();
    drive(0, 1'b0, 8'd0);
    tick(); tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy1); end
    for (int c = 0; c < 15; c++) begin
      if (done1) dones++;
      tick();
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_done_pulses got=%0d exp=0", dones); end
    scan(0, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== exp_seg(0, 4, k)) begin
        errors++; $display("FAIL abort_digit%0d got=%h exp=%h", k, got[k], exp_seg(0, 4, k)); end
    end
    RST = 1'b1;
    drive(0, 1'b1, 8'd55);
    tick();
    RST = 1'b0;
    drive(0, 1'b0, 8'd0);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_priority_busy got=%b exp=0", busy1); end
    tick();
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_priority_busy2 got=%b exp=0", busy1); end
  endtask

  task automatic test_leading_zero;
    int lat, bb;
    int vals [2] = '{7, 0};
    for (int n = 0; n < 2; n++) begin
      convert(0, 8'(vals[n]), lat, bb);
      scan(0, 4);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== exp_seg(vals[n], 4, k)) begin
          errors++; $display("FAIL lz_v%0d_digit%0d got=%h exp=%h", vals[n], k, got[k], exp_seg(vals[n], 4, k)); end
      end
    end
  endtask

  task automatic test_random;
    int lat, bb, v;
    for (int n = 0; n < 12; n++) begin
      v = $urandom_range(0, 255);
      convert(0, 8'(v), lat, bb);
      checks++; if (lat !== 9) begin errors++; $display("FAIL rnd4_latency v=%0d got=%0d exp=9", v, lat); end
      checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL rnd4_ovf v=%0d got=%b exp=0", v, ovf1); end
      scan(0, 4);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== exp_seg(v, 4, k)) begin
          errors++; $display("FAIL rnd4_digit%0d v=%0d got=%h exp=%h", k, v, got[k], exp_seg(v, 4, k)); end
      end
      v = $urandom_range(0, 255);
      convert(1, 8'(v), lat, bb);
      checks++; if (ovf2 !== (v > 99)) begin
        errors++; $display("FAIL rnd2_ovf v=%0d got=%b exp=%b", v, ovf2, (v > 99)); end
      scan(1, 2);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got[k] !== exp_seg(v, 2, k)) begin
          errors++; $display("FAIL rnd2_digit%0d v=%0d got=%h exp=%h", k, v, got[k], exp_seg(v, 2, k)); end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    drive(0, 1'b0, 8'd0);
    drive(1, 1'b0, 8'd0);
    drive(2, 1'b0, 8'd0);
    tick();
    tick();
    test_reset();
    test_scan_an();
    test_conversion();
    test_ovf();
    test_load_ignored();
    test_back_to_back();
    test_reset_abort();
    test_leading_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_seg_display.md
BCD_SEG_DISPLAY -- requirements
Module: bcd_seg_display

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bit width of the binary input value (2..20).
REQ-002 SHALL have parameter DIGITS, default 4, meaning the number of seven-segment digits driven (1..8).
REQ-003 SHALL have parameter REFRESH_BITS, default 16, meaning the prescaler width; each digit is held for 2^REFRESH_BITS clocks.
REQ-004 SHALL have port CLK, input, 1, the single system clock; all logic is rising-edge.
REQ-005 SHALL have port RST, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port VALUE, input, WIDTH, the unsigned binary value to display.
REQ-007 SHALL have port LOAD, input, 1, a start-conversion request sampled on the rising edge.
REQ-008 SHALL have port BUSY, output, 1, high while a conversion is in progress.
REQ-009 SHALL have port DONE, output, 1, a one-cycle pulse when the new value is latched for display.
REQ-010 SHALL have port OVF, output, 1, high when the last converted value exceeds 10^DIGITS-1.
REQ-011 SHALL have port AN, output, DIGITS, active-low digit enables, with exactly one digit low at a time.
REQ-012 SHALL have port seg, output, 7, active-low segments; bit 0 is segment a and bit 6 is segment g.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and FINISH, converting binary to BCD by sequential double-dabble.
REQ-014 SHALL, in IDLE with LOAD=1, capture VALUE into the shift register, clear the BCD accumulator and enter SHIFT.
REQ-015 SHALL, in SHIFT, perform one add-3-if-greater-than-4 correction on every BCD nibble followed by a 1-bit left shift each cycle, for exactly WIDTH cycles, and then enter FINISH.
REQ-016 SHALL, in FINISH, copy the low DIGITS BCD nibbles to the display register, update OVF, pulse DONE for one cycle and return to IDLE.
REQ-017 SHALL set OVF=1 when any BCD nibble above index DIGITS-1 is nonzero.
REQ-018 SHALL assert DONE in the cycle that is WIDTH+1 cycles after the cycle in which LOAD was sampled.
REQ-019 SHALL keep BUSY=1 from the cycle after LOAD is sampled through the DONE cycle inclusive.
REQ-020 SHALL ignore LOAD while BUSY=1: no restart and no queueing.
REQ-021 SHALL accept a LOAD in the cycle immediately after DONE.
REQ-022 SHALL size the BCD accumulator to ceil(WIDTH*log10(2)) nibbles, with a minimum of DIGITS nibbles.
REQ-023 SHALL hold the old display register, unchanged and still scanned, during conversion, updating it only at FINISH.
REQ-024 SHALL increment the scan prescaler every cycle and advance the digit index on prescaler wrap, with the digit index wrapping from DIGITS-1 to 0 for any DIGITS, including non-powers of 2.
REQ-025 SHALL drive AN low only at the current digit index; digit 0 is the least significant digit.
REQ-026 SHALL decode digit values 0-9 to standard segment patterns and drive any value above 9 as blank.
REQ-027 SHALL drive every digit as a dash (only segment g lit) when OVF=1.

Reset
REQ-028 SHALL, on RST=1 at a clock edge, go to IDLE with BUSY=0, DONE=0 and OVF=0, the display register at 0, the prescaler at 0 and the digit index at 0.
REQ-029 SHALL, in the first cycle after reset, drive AN to all-ones except AN[0]=0 and drive seg to the pattern for "0".
REQ-030 SHALL let RST abort a conversion in progress, with no DONE pulse and the display register at 0.
REQ-031 SHALL give RST priority over a simultaneous LOAD.

Configuration
REQ-032 SHALL, when macro BCD_SEG_LEADING_ZERO_BLANK_EN is defined, blank zero digits above the most significant nonzero digit, always showing digit 0; the OVF dash pattern overrides blanking.
REQ-033 SHALL, when BCD_SEG_LEADING_ZERO_BLANK_EN is undefined, show all digits, including leading zeros.

Structure
REQ-034 SHALL place the FSM state enum, the seven-segment constants for 0-9, DASH and BLANK, and the nibble-count function in shared package bcd_seg_pkg.
REQ-035 SHALL implement nibble-to-segment decoding in the single combinational sub-module seg7_decode, instantiated once on the muxed digit.

Verification
REQ-036 SHALL verify: WIDTH=8, DIGITS=4, VALUE=255, LOAD pulse -> DONE exactly 9 cycles later; digits 3..0 are 0,2,5,5; OVF=0.
REQ-037 SHALL verify: WIDTH=8, DIGITS=2, VALUE=100 -> OVF=1 and both digits dash; then VALUE=99 -> OVF=0, display "99".
REQ-038 SHALL verify: LOAD with VALUE=42, then LOAD with VALUE=7 three cycles later -> the second LOAD is ignored, the display is "0042" and one DONE pulse occurs.
REQ-039 SHALL verify: RST asserted 4 cycles into a conversion of 200 -> no DONE, display "0000", BUSY=0 next cycle.
REQ-040 SHALL verify: REFRESH_BITS=2, DIGITS=3 -> AN sequence 110, 101, 011, 110, each held 4 cycles.
REQ-041 SHALL verify: with BCD_SEG_LEADING_ZERO_BLANK_EN and VALUE=7 on 4 digits -> digits 3..1 blank and digit 0 shows 7; with VALUE=0 -> only digit 0 shows "0".
